subtrator_serial: RTL and testbench
===================================

SUBTRATOR_SERIAL -- requirements
Module: subtrator_serial

Interface
REQ-001 The block SHALL have parameter NUM_BITS, default 8, giving the operand and result width in bits.
REQ-002 The block SHALL have port clock, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit; reset is asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit, a request to begin a subtraction, sampled on the rising edge of clock.
REQ-005 The block SHALL have ports A and B, input, NUM_BITS bits each, signed two's-complement minuend and subtrahend.
REQ-006 The block SHALL have port busy, output, 1 bit, high while a subtraction is in progress.
REQ-007 The block SHALL have port done, output, 1 bit, a one-cycle pulse marking valid results.
REQ-008 The block SHALL have port S, output, NUM_BITS bits, the signed result A - B.
REQ-009 The block SHALL have ports Z, N and P, output, 1 bit each, the zero, negative and even flags of S.
REQ-010 The block SHALL have port V, output, 1 bit, the signed overflow flag, present only under SUBTRATOR_OVF_EN.

Function
REQ-011 The block SHALL implement a state machine with states IDLE, RUN and DONE.
REQ-012 In IDLE, start=1 at an edge SHALL latch A and B, clear the bit counter, set the internal borrow to 0, and enter RUN.
REQ-013 In RUN, each edge SHALL compute one result bit, LSB first, as difference = a_i XOR b_i XOR borrow, with borrow_next = (~a_i & b_i) | (~(a_i ^ b_i) & borrow).
REQ-014 The result bit SHALL be shifted into an internal register, and the counter SHALL increment by one per edge.
REQ-015 After exactly NUM_BITS RUN edges, the block SHALL update S, Z, N, P (and V) and enter DONE.
REQ-016 Latency: if start is sampled at edge t0, results and done SHALL be valid after edge t0+NUM_BITS (edge t0+8 by default).
REQ-017 done SHALL be high for exactly one cycle, in DONE, then the block SHALL return to IDLE unless start is high at that edge.
REQ-018 busy SHALL be high in RUN and low in IDLE and DONE.
REQ-019 start SHALL be ignored while in RUN, and inputs A and B SHALL be ignored except at the accepting edge.
REQ-020 start=1 at the edge leaving DONE SHALL be accepted, so back-to-back operation has no idle cycle.
REQ-021 S and the flags SHALL hold their last values until the next completion and SHALL NOT change during RUN.
REQ-022 Flags SHALL be Z = (S == 0), N = S[NUM_BITS-1], P = ~S[0].
REQ-023 The result SHALL wrap modulo 2^NUM_BITS, with no saturation.

Reset
REQ-024 Asserting reset SHALL immediately force state IDLE, counter 0, and S, Z, N, P, V, busy, done to 0.
REQ-025 Reset mid-operation SHALL abort the subtraction with no done pulse, and a fresh start SHALL be required after release.

Configuration
REQ-026 With macro SUBTRATOR_OVF_EN defined, port V SHALL exist.
REQ-027 V SHALL be updated at completion as (A[MSB] != B[MSB]) & (S[MSB] != A[MSB]), and SHALL reset to 0.
REQ-028 Without SUBTRATOR_OVF_EN, port V and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 A=5, B=3, start pulse -> done after 8 edges; S=0x02, Z=0, N=0, P=1; busy high for 8 cycles.
REQ-030 A=3, B=5 -> S=0xFE (-2), Z=0, N=1, P=1, V=0.
REQ-031 A=7, B=7 -> S=0x00, Z=1, N=0, P=1; then A=-128, B=1 with SUBTRATOR_OVF_EN -> S=0x7F, N=0, P=0, V=1.
REQ-032 Start held high through RUN with A and B changing -> the first latched operands are used, and a second result follows immediately after the done cycle.
REQ-033 Reset asserted at RUN cycle 4 -> all outputs 0 at once and no done pulse; a new start with 10 - 20 gives S=0xF6, N=1, P=1.

Source files
------------

// File: rtl/subtrator_serial.sv
// Bit-serial signed subtractor S = A - B, LSB first, one bit per clock; V port only with SUBTRATOR_OVF_EN.
// Latency NUM_BITS edges from the accepting edge to done; start is ignored while busy (no backpressure).
module subtrator_serial #(
    parameter int NUM_BITS = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [NUM_BITS-1:0] A,
    input  logic [NUM_BITS-1:0] B,
    output logic                busy,
    output logic                done,
    output logic [NUM_BITS-1:0] S,
    output logic                Z,
    output logic                N,
    output logic                P
`ifdef SUBTRATOR_OVF_EN
    ,
    output logic                V
`endif
);

    localparam int CW = $clog2(NUM_BITS + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state_q, state_d;
    logic [NUM_BITS-1:0]   a_q, a_d, b_q, b_d;
    logic [NUM_BITS-1:0]   res_q, res_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  brw_q, brw_d;
    logic [NUM_BITS-1:0]   s_q, s_d;
    logic                  z_q, z_d, n_q, n_d, p_q, p_d;
`ifdef SUBTRATOR_OVF_EN
    logic                  v_q, v_d;
`endif

    logic [NUM_BITS-1:0]   a_sh, b_sh, res_shift;
    logic                  a_bit, b_bit, diff_bit, brw_nxt;

    always_comb begin
        a_sh      = a_q >> cnt_q;
        b_sh      = b_q >> cnt_q;
        a_bit     = a_sh[0];
        b_bit     = b_sh[0];
        diff_bit  = a_bit ^ b_bit ^ brw_q;
        brw_nxt   = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & brw_q);
        // result fills from the MSB end so it is aligned after NUM_BITS shifts
        res_shift = {diff_bit, res_q[NUM_BITS-1:1]};

        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        brw_d   = brw_q;
        s_d     = s_q;
        z_d     = z_q;
        n_d     = n_q;
        p_d     = p_q;
`ifdef SUBTRATOR_OVF_EN
        v_d     = v_q;
`endif

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    res_d   = '0;
                    cnt_d   = '0;
                    brw_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d = res_shift;
                brw_d = brw_nxt;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(NUM_BITS - 1)) begin
                    s_d     = res_shift;
                    z_d     = (res_shift == '0);
                    n_d     = res_shift[NUM_BITS-1];
                    p_d     = ~res_shift[0];
`ifdef SUBTRATOR_OVF_EN
                    v_d     = (a_q[NUM_BITS-1] != b_q[NUM_BITS-1]) &
                              (res_shift[NUM_BITS-1] != a_q[NUM_BITS-1]);
`endif
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            brw_q   <= 1'b0;
            s_q     <= '0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            p_q     <= 1'b0;
`ifdef SUBTRATOR_OVF_EN
            v_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            brw_q   <= brw_d;
            s_q     <= s_d;
            z_q     <= z_d;
            n_q     <= n_d;
            p_q     <= p_d;
`ifdef SUBTRATOR_OVF_EN
            v_q     <= v_d;
`endif
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign S    = s_q;
    assign Z    = z_q;
    assign N    = n_q;
    assign P    = p_q;
`ifdef SUBTRATOR_OVF_EN
    assign V    = v_q;
`endif

endmodule

// File: tb/tb_subtrator_serial.sv
// Randomized bench for subtrator_serial against an arithmetic reference model; V checked only with SUBTRATOR_OVF_EN.
module tb_subtrator_serial;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] A, B, S;
    logic         busy, done, Z, N, P;
`ifdef SUBTRATOR_OVF_EN
    logic         V;
`endif

    int           n_checks = 0;
    int           n_errors = 0;
    logic [W-1:0] last_s = '0;

    subtrator_serial #(.NUM_BITS(W)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .S     (S),
        .Z     (Z),
        .N     (N),
        .P     (P)
`ifdef SUBTRATOR_OVF_EN
        ,
        .V     (V)
`endif
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: wrapped difference plus flags from plain integer arithmetic.
    task automatic check_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] es;
        int           sdiff;
        es    = a - b;
        sdiff = int'($signed(a)) - int'($signed(b));
        check_val({tag, "_S"}, 32'(S), 32'(es));
        check_val({tag, "_Z"}, 32'(Z), 32'(es == 0));
        check_val({tag, "_N"}, 32'(N), 32'(int'($signed(es)) < 0));
        check_val({tag, "_P"}, 32'(P), 32'((es % 2) == 0));
`ifdef SUBTRATOR_OVF_EN
        check_val({tag, "_V"}, 32'(V), 32'((sdiff > 127) || (sdiff < -128)));
`else
        if (sdiff > 1000) $display("unreachable");
`endif
        last_s = es;
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        int lat, bcnt;
        @(negedge clock);
        A = a; B = b; start = 1'b1;
        @(negedge clock);
        lat  = 0;
        bcnt = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) bcnt++;
            if (lat == 3) check_val({tag, "_hold"}, 32'(S), 32'(last_s));
            start = 1'($urandom_range(0, 1));
            A     = W'($urandom);
            B     = W'($urandom);
            @(negedge clock);
            lat++;
        end
        start = 1'b0;
        check_val({tag, "_lat"}, 32'(lat), 32'(W));
        check_val({tag, "_busy"}, 32'(bcnt), 32'(W));
        check_result(tag, a, b);
        @(negedge clock);
        check_val({tag, "_pulse"}, 32'(done), 32'd0);
        check_val({tag, "_idle"}, 32'(busy), 32'd0);
        check_val({tag, "_keep"}, 32'(S), 32'(last_s));
    endtask

    initial begin
        int           lat, seen;
        logic [W-1:0] a1, b1, a2, b2;

        reset = 1'b1; start = 1'b0; A = '0; B = '0;
        repeat (2) @(negedge clock);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_S", 32'(S), 32'd0);
        check_val("rst_ZNP", 32'({Z, N, P}), 32'd0);
        reset = 1'b0;

        run_op("d5m3", 8'd5, 8'd3);
        run_op("d3m5", 8'd3, 8'd5);
        run_op("d7m7", 8'd7, 8'd7);
        run_op("dm128", 8'h80, 8'h01);

        // back-to-back: start stays high, operands churn during RUN
        a1 = W'($urandom); b1 = W'($urandom);
        a2 = W'($urandom); b2 = W'($urandom);
        @(negedge clock);
        A = a1; B = b1; start = 1'b1;
        @(negedge clock);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            A = W'($urandom); B = W'($urandom);
            @(negedge clock);
            lat++;
        end
        check_val("b2b_lat1", 32'(lat), 32'(W));
        check_result("b2b1", a1, b1);
        A = a2; B = b2;
        @(negedge clock);
        check_val("b2b_nogap_busy", 32'(busy), 32'd1);
        check_val("b2b_nogap_done", 32'(done), 32'd0);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            A = W'($urandom); B = W'($urandom);
            @(negedge clock);
            lat++;
        end
        start = 1'b0;
        check_val("b2b_lat2", 32'(lat), 32'(W));
        check_result("b2b2", a2, b2);
        @(negedge clock);

        // reset during RUN aborts without a done pulse
        @(negedge clock);
        A = W'($urandom); B = W'($urandom); start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        check_val("pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check_val("mid_rst_busy", 32'(busy), 32'd0);
        check_val("mid_rst_done", 32'(done), 32'd0);
        check_val("mid_rst_S", 32'(S), 32'd0);
        check_val("mid_rst_ZNP", 32'({Z, N, P}), 32'd0);
`ifdef SUBTRATOR_OVF_EN
        check_val("mid_rst_V", 32'(V), 32'd0);
`endif
        last_s = '0;
        @(negedge clock);
        reset = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clock);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        check_val("rst_nodone", 32'(seen), 32'd0);
        run_op("d10m20", 8'd10, 8'd20);

        for (int i = 0; i < 20; i++) begin
            run_op("rnd", W'($urandom), W'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
